// File: rtl/cla_seq_addsub.sv
// rtl/cla_seq_addsub.sv - multi-cycle adder/subtractor resolving one GROUP-bit lookahead slice per clock
// Sum, carry-out, signed overflow and zero flags, with a start/busy/done handshake.
module cla_seq_addsub #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;
  localparam int IW = (NG > 1) ? $clog2(NG) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  int               base;
  logic [GROUP-1:0] ga;
  logic [GROUP-1:0] gb;
  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] sum;
  logic [GROUP:0]   c;
  logic             term;
  logic [WIDTH-1:0] s_next;

  assign base = GROUP * int'(idx);
  assign last = (int'(idx) == NG - 1);
  assign busy = (state == RUN);

  // Each slice carry is a flat sum of products of g/p terms and the incoming
  // group carry, so there is no ripple path inside the slice.
  always_comb begin
    ga     = a_r[base +: GROUP];
    gb     = b_r[base +: GROUP];
    g      = ga & gb;
    p      = ga | gb;
    c      = '0;
    term   = 1'b0;
    c[0]   = carry;
    for (int k = 1; k <= GROUP; k++) begin
      term = carry;
      for (int m = 0; m < k; m++) term = term & p[m];
      c[k] = term;
      for (int j = 0; j < k; j++) begin
        term = g[j];
        for (int m = j + 1; m < k; m++) term = term & p[m];
        c[k] = c[k] | term;
      end
    end
    sum    = ga ^ gb ^ c[GROUP-1:0];
    s_next = s;
    s_next[base +: GROUP] = sum;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      s     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // Subtraction is a + ~b + 1: invert B once at capture, force carry-in.
        a_r   <= a;
        b_r   <= b ^ {WIDTH{sub}};
        carry <= sub | ci;
        idx   <= '0;
      end else if (state == RUN) begin
        s     <= s_next;
        carry <= c[GROUP];
        idx   <= last ? '0 : idx + 1'b1;
        if (last) begin
          co   <= c[GROUP];
          ovf  <= c[GROUP-1] ^ c[GROUP];
          zero <= (s_next == '0);
          done <= 1'b1;
        end
      end
    end
  end

endmodule
